// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-memory arbiter.
//   dmem_arb_state_t : arbiter FSM states (IDLE, RMW)
//   dmem_arb_id_t    : requester identity (core LSU, DMA/debug)
//   byte_merge       : per-byte select between an old and a new word
package dmem_arb_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_RMW = 1'b1} dmem_arb_state_t;
  typedef enum logic {REQ_CORE = 1'b0, REQ_DMA = 1'b1} dmem_arb_id_t;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // Byte i comes from new_word when be[i] is set, otherwise from old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester channels and the memory port.
//   core_* / dma_* : requester side (req, we, addr, wdata, be -> gnt, rvalid, rdata)
//   mem_*          : memory side (addr, wdata, rw -> rdata, combinational read)
// Handshake: a requester raises req with we/addr/wdata/be stable and holds them
// until it sees gnt high in the same cycle; the transfer is accepted in that
// cycle. Keeping req high afterwards is a fresh request. Exactly one rvalid pulse
// answers each grant (1 cycle later, 2 for a merged sub-word store); rdata is
// meaningful only with rvalid and otherwise keeps its last value.
// Modports: slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_be;
  logic        core_gnt;
  logic        core_rvalid;
  logic [31:0] core_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_be;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_be,
    output core_gnt, core_rvalid, core_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_be,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_rw,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_be,
    input  core_gnt, core_rvalid, core_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_be,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_rw,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// dmem_rr_pick: combinational two-way round-robin picker.
//   req[1:0]    in  : bit 0 = core, bit 1 = DMA
//   last_winner in  : requester granted most recently (register kept by parent)
//   grant[1:0]  out : one-hot grant, zero when nobody requests
//   winner      out : id of the granted requester (REQ_CORE when none)
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0]   req,
  input  dmem_arb_id_t last_winner,
  output logic [1:0]   grant,
  output dmem_arb_id_t winner
);

  always_comb begin
    grant  = 2'b00;
    winner = REQ_CORE;
    case (req)
      2'b01: begin grant = 2'b01; winner = REQ_CORE; end
      2'b10: begin grant = 2'b10; winner = REQ_DMA;  end
      2'b11: begin
        // Contested: whoever did not win last time goes now.
        if (last_winner == REQ_CORE) begin
          grant  = 2'b10;
          winner = REQ_DMA;
        end else begin
          grant  = 2'b01;
          winner = REQ_CORE;
        end
      end
      default: begin
        grant  = 2'b00;
        winner = REQ_CORE;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between core LSU and DMA.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave (requester channels + memory port)
//   dbg_state  : current FSM state
// Parameters: ADDR_W (address bits forwarded to memory), CORE_FIRST (core wins
// the first contested cycle after reset when 1).
// Optional feature macro DMEM_ARB_RMW_EN: sub-word stores become a read cycle
// followed by a merged write cycle. Without it every store writes the full word.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter bit CORE_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus,
  output dmem_arb_state_t dbg_state
);

  localparam int UPPER_W = 32 - ADDR_W;

  dmem_arb_state_t state;
  dmem_arb_id_t    last_winner;
  logic [1:0]      pick_grant;
  dmem_arb_id_t    pick_id;
  logic            grant_any;
  logic            sel_we;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic            sel_partial;
  logic            store_writes;

  logic            core_rvalid_q;
  logic            dma_rvalid_q;
  logic [31:0]     core_rdata_q;
  logic [31:0]     dma_rdata_q;

  // Upper address bits never reach memory; be is irrelevant without merging.
  logic            unused_bits;

  dmem_rr_pick u_pick (
    .req         ({bus.dma_req, bus.core_req}),
    .last_winner (last_winner),
    .grant       (pick_grant),
    .winner      (pick_id)
  );

  assign sel_we    = (pick_id == REQ_DMA) ? bus.dma_we    : bus.core_we;
  assign sel_addr  = (pick_id == REQ_DMA) ? bus.dma_addr  : bus.core_addr;
  assign sel_wdata = (pick_id == REQ_DMA) ? bus.dma_wdata : bus.core_wdata;
  assign grant_any = rst_n && (state == ST_IDLE) && (|pick_grant);

`ifdef DMEM_ARB_RMW_EN
  dmem_arb_state_t    state_next;
  logic [3:0]         sel_be;
  logic [ADDR_W-1:0]  rmw_addr;
  logic [31:0]        rmw_old;
  logic [31:0]        rmw_wdata;
  logic [3:0]         rmw_be;
  dmem_arb_id_t       rmw_id;

  assign sel_be       = (pick_id == REQ_DMA) ? bus.dma_be : bus.core_be;
  // be==0 is a no-op store, be==F a plain write; anything else needs a merge.
  assign sel_partial  = sel_we && (sel_be != BE_FULL) && (sel_be != BE_NONE);
  assign store_writes = (sel_be == BE_FULL);
  assign unused_bits  = ^{bus.core_addr[31:ADDR_W], bus.dma_addr[31:ADDR_W]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant_any && sel_partial) state_next = ST_RMW;
      ST_RMW:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Context of the pending merge, captured while the old word is on mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmw_addr  <= '0;
      rmw_old   <= '0;
      rmw_wdata <= '0;
      rmw_be    <= '0;
      rmw_id    <= REQ_CORE;
    end else if (grant_any && sel_partial) begin
      rmw_addr  <= sel_addr[ADDR_W-1:0];
      rmw_old   <= bus.mem_rdata;
      rmw_wdata <= sel_wdata;
      rmw_be    <= sel_be;
      rmw_id    <= pick_id;
    end
  end
`else
  assign state        = ST_IDLE;
  assign sel_partial  = 1'b0;
  assign store_writes = 1'b1;
  assign unused_bits  = ^{bus.core_addr[31:ADDR_W], bus.dma_addr[31:ADDR_W],
                          bus.core_be, bus.dma_be};
`endif

  // Output logic: grants and memory port. Everything is held quiet in reset.
  always_comb begin
    bus.core_gnt  = 1'b0;
    bus.dma_gnt   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_rw    = 1'b0;
    if (rst_n) begin
      if (state == ST_IDLE) begin
        bus.core_gnt = pick_grant[0];
        bus.dma_gnt  = pick_grant[1];
        if (|pick_grant) begin
          bus.mem_addr = {{UPPER_W{1'b0}}, sel_addr[ADDR_W-1:0]};
          if (sel_we) begin
            bus.mem_wdata = sel_wdata;
            bus.mem_rw    = store_writes;
          end
        end
      end
`ifdef DMEM_ARB_RMW_EN
      else begin
        bus.mem_addr  = {{UPPER_W{1'b0}}, rmw_addr};
        bus.mem_wdata = byte_merge(rmw_old, rmw_wdata, rmw_be);
        bus.mem_rw    = 1'b1;
      end
`endif
    end
  end

  // Arbitration history and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner   <= CORE_FIRST ? REQ_DMA : REQ_CORE;
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dma_rdata_q   <= '0;
    end else begin
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      if (grant_any) last_winner <= pick_id;
      // Loads return the word read in the grant cycle; stores return zero.
      if (grant_any && !sel_partial) begin
        if (pick_id == REQ_CORE) begin
          core_rvalid_q <= 1'b1;
          core_rdata_q  <= sel_we ? 32'h0 : bus.mem_rdata;
        end else begin
          dma_rvalid_q  <= 1'b1;
          dma_rdata_q   <= sel_we ? 32'h0 : bus.mem_rdata;
        end
      end
`ifdef DMEM_ARB_RMW_EN
      // Merged store answers once its write cycle completes.
      if (state == ST_RMW) begin
        if (rmw_id == REQ_CORE) begin
          core_rvalid_q <= 1'b1;
          core_rdata_q  <= 32'h0;
        end else begin
          dma_rvalid_q  <= 1'b1;
          dma_rdata_q   <= 32'h0;
        end
      end
`endif
    end
  end

  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.dma_rvalid  = dma_rvalid_q;
  assign bus.dma_rdata   = dma_rdata_q;
  assign dbg_state       = state;

endmodule
